// File: rtl/drive_ramp_ctrl.sv
// Two-sided motor drive with ticked duty ramping and a shared 7-step PWM.
// Optional emergency brake is compiled in when DRIVE_BRAKE_EN is defined.
module drive_ramp_ctrl #(
  parameter int unsigned RAMP_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       left_req,
  input  logic       right_req,
  input  logic       brake,
  output logic       pwm_left,
  output logic       pwm_right,
  output logic [2:0] duty_left,
  output logic [2:0] duty_right,
  output logic       ramping
);

  typedef enum logic [1:0] {
    StIdle,
    StRampUp,
    StRun,
    StRampDown
  } state_e;

  localparam logic [7:0] PresMax = 8'(RAMP_DIV - 1);
  localparam logic [2:0] DutyMax = 3'd7;
  localparam logic [2:0] PwmMax  = 3'd6;

  logic [7:0] r_presc;
  logic [2:0] r_pwm_cnt;
  logic       w_tick;
  logic [1:0] w_req;
  logic       w_brake;

  state_e     r_state   [2];
  state_e     w_state_d [2];
  logic [2:0] r_duty    [2];
  logic [2:0] w_duty_d  [2];
  logic [1:0] r_pwm;
  logic [1:0] w_pwm_d;
  logic       r_ramping;
  logic       w_ramping_d;

  assign w_req  = {right_req, left_req};
  assign w_tick = (r_presc == PresMax);

`ifdef DRIVE_BRAKE_EN
  assign w_brake = brake;
`else
  logic w_unused_brake;
  assign w_unused_brake = brake;
  assign w_brake        = 1'b0;
`endif

  // Prescaler and PWM counter free-run; only rst restarts them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc   <= 8'd0;
      r_pwm_cnt <= 3'd0;
    end else begin
      r_presc   <= w_tick ? 8'd0 : r_presc + 8'd1;
      r_pwm_cnt <= (r_pwm_cnt == PwmMax) ? 3'd0 : r_pwm_cnt + 3'd1;
    end
  end

  always_comb begin
    w_ramping_d = 1'b0;
    w_pwm_d     = 2'b00;
    for (int i = 0; i < 2; i++) begin
      w_duty_d[i]  = r_duty[i];
      w_state_d[i] = r_state[i];
      w_pwm_d[i]   = (r_pwm_cnt < r_duty[i]);

      if (w_tick) begin
        if (w_req[i] && (r_duty[i] != DutyMax)) begin
          w_duty_d[i] = r_duty[i] + 3'd1;
        end else if (!w_req[i] && (r_duty[i] != 3'd0)) begin
          w_duty_d[i] = r_duty[i] - 3'd1;
        end
      end

      // Transitions look at the post-tick duty so state and duty move together.
      unique case (r_state[i])
        StIdle: begin
          if (w_req[i]) w_state_d[i] = StRampUp;
        end
        StRampUp: begin
          if (!w_req[i]) begin
            w_state_d[i] = (w_duty_d[i] == 3'd0) ? StIdle : StRampDown;
          end else if (w_duty_d[i] == DutyMax) begin
            w_state_d[i] = StRun;
          end
        end
        StRun: begin
          if (!w_req[i]) w_state_d[i] = StRampDown;
        end
        StRampDown: begin
          if (w_req[i]) begin
            w_state_d[i] = (w_duty_d[i] == DutyMax) ? StRun : StRampUp;
          end else if (w_duty_d[i] == 3'd0) begin
            w_state_d[i] = StIdle;
          end
        end
      endcase

      if (w_brake) begin
        w_duty_d[i]  = 3'd0;
        w_state_d[i] = StIdle;
        w_pwm_d[i]   = 1'b0;
      end

      if ((w_state_d[i] == StRampUp) || (w_state_d[i] == StRampDown)) begin
        w_ramping_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_duty[i]  <= 3'd0;
        r_state[i] <= StIdle;
      end
      r_pwm     <= 2'b00;
      r_ramping <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        r_duty[i]  <= w_duty_d[i];
        r_state[i] <= w_state_d[i];
      end
      r_pwm     <= w_pwm_d;
      r_ramping <= w_ramping_d;
    end
  end

  assign duty_left  = r_duty[0];
  assign duty_right = r_duty[1];
  assign pwm_left   = r_pwm[0];
  assign pwm_right  = r_pwm[1];
  assign ramping    = r_ramping;

endmodule

// File: tb/tb_drive_ramp_ctrl.sv
// Scoreboard bench for drive_ramp_ctrl: a driver pushes model predictions per edge,
// a monitor pops and compares just after each rising edge.
module tb_drive_ramp_ctrl;

  localparam int DIV = 4;
`ifdef DRIVE_BRAKE_EN
  localparam bit BrakeEn = 1'b1;
`else
  localparam bit BrakeEn = 1'b0;
`endif

  logic       clk = 1'b1;
  logic       rst = 1'b1;
  logic       left_req = 1'b0;
  logic       right_req = 1'b0;
  logic       brake = 1'b0;
  logic       pwm_left;
  logic       pwm_right;
  logic [2:0] duty_left;
  logic [2:0] duty_right;
  logic       ramping;

  drive_ramp_ctrl #(.RAMP_DIV(DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .left_req  (left_req),
    .right_req (right_req),
    .brake     (brake),
    .pwm_left  (pwm_left),
    .pwm_right (pwm_right),
    .duty_left (duty_left),
    .duty_right(duty_right),
    .ramping   (ramping)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dl;
    int dr;
    int pl;
    int pr;
    int rmp;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err = 0;

  // Reference: duties as plain integers, edges counted since the last reset edge.
  int m_dl = 0;
  int m_dr = 0;
  int m_k = 0;

  function automatic int step_duty(int d, bit req);
    if (req) return (d < 7) ? d + 1 : 7;
    return (d > 0) ? d - 1 : 0;
  endfunction

  function automatic int side_ramp(int d, bit req);
    return req ? int'(d < 7) : int'(d > 0);
  endfunction

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic drive(input bit r, input bit l, input bit rr, input bit b, input int n);
    exp_t e;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      rst = r; left_req = l; right_req = rr; brake = b;
      if (r) begin
        m_dl = 0; m_dr = 0; m_k = 0;
        e = '{0, 0, 0, 0, 0};
      end else begin
        if (b && BrakeEn) begin
          m_dl = 0; m_dr = 0;
          e = '{0, 0, 0, 0, 0};
        end else begin
          e.pl = int'((m_k % 7) < m_dl);
          e.pr = int'((m_k % 7) < m_dr);
          if ((m_k % DIV) == DIV - 1) begin
            m_dl = step_duty(m_dl, l);
            m_dr = step_duty(m_dr, rr);
          end
          e.dl  = m_dl;
          e.dr  = m_dr;
          e.rmp = side_ramp(m_dl, l) | side_ramp(m_dr, rr);
        end
        m_k++;
      end
      q.push_back(e);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("duty_left", int'(duty_left), e.dl);
      chk("duty_right", int'(duty_right), e.dr);
      chk("pwm_left", int'(pwm_left), e.pl);
      chk("pwm_right", int'(pwm_right), e.pr);
      chk("ramping", int'(ramping), e.rmp);
    end
  end

  initial begin
    // Left ramps up to RUN, then down to IDLE; right stays idle.
    drive(1, 0, 0, 0, 2);
    drive(0, 1, 0, 0, 40);
    drive(0, 0, 0, 0, 36);
    // Reversal mid-ramp around duty 3.
    drive(0, 1, 0, 0, 13);
    drive(0, 0, 0, 0, 12);
    drive(0, 1, 0, 0, 6);
    drive(0, 0, 0, 0, 30);
    // Both sides in lockstep from reset.
    drive(1, 1, 1, 0, 1);
    drive(0, 1, 1, 0, 40);
    // Reset with both sides at duty 5.
    drive(1, 1, 1, 0, 1);
    drive(0, 1, 1, 0, 20);
    drive(1, 1, 1, 0, 1);
    drive(0, 1, 1, 0, 12);
    // Brake at full duty, then release with requests held.
    drive(0, 1, 1, 0, 24);
    drive(0, 1, 1, 1, 5);
    drive(0, 1, 1, 0, 12);
    // Randomised segments.
    for (int s = 0; s < 80; s++) begin
      bit l, rr, b, r;
      l  = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      b  = ($urandom_range(0, 9) == 0);
      r  = ($urandom_range(0, 29) == 0);
      drive(r, l, rr, b, r ? 1 : (b ? int'($urandom_range(1, 5)) : int'($urandom_range(1, 25))));
    end
    drive(0, 0, 0, 0, 2);
    @(posedge clk);
    #3;
    if (q.size() != 0) chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
